// File: rtl/neureka_norm_serializer_if.sv
// Valid/ready stream bundle carrying a data word and byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/neureka_norm_serializer.sv
// Splits wide normalization words into 8/16/32-bit elements, extended to OUT_W,
// one element per output handshake, with a single holding word and same-cycle refill.
module neureka_norm_serializer #(
    parameter int unsigned BW    = 256,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic                   start_i,
    input  logic [1:0]             mode_i,
    input  logic                   signed_i,
    input  logic [LEN_W-1:0]       len_i,
    hwpe_stream_intf_stream.sink   norm_i,
    hwpe_stream_intf_stream.source norm_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [LEN_W-1:0]       count_o
);

    localparam int unsigned IDX_W = $clog2(BW / 8);
    localparam int unsigned SH_W  = IDX_W + 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               signed_q, signed_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BW-1:0]      word_q, word_d;
    logic               reg_valid_q, reg_valid_d;

    logic [IDX_W-1:0]   epw_m1;
    logic [SH_W-1:0]    shamt;
    logic [BW-1:0]      shifted;
    logic [OUT_W-1:0]   elem_ext;
    logic               last_in_word, run, out_valid, out_hs, in_ready, in_hs;

    // Element geometry follows the latched mode; reserved mode 11 behaves as 32b.
    always_comb begin
        epw_m1 = IDX_W'(BW / 32 - 1);
        shamt  = SH_W'(idx_q) << 5;
        case (mode_q)
            2'b00: begin
                epw_m1 = IDX_W'(BW / 8 - 1);
                shamt  = SH_W'(idx_q) << 3;
            end
            2'b01: begin
                epw_m1 = IDX_W'(BW / 16 - 1);
                shamt  = SH_W'(idx_q) << 4;
            end
            default: ;
        endcase
    end

    assign shifted = word_q >> shamt;

    always_comb begin
        case (mode_q)
            2'b00:   elem_ext = signed_q ? OUT_W'($signed(shifted[7:0]))  : OUT_W'(shifted[7:0]);
            2'b01:   elem_ext = signed_q ? OUT_W'($signed(shifted[15:0])) : OUT_W'(shifted[15:0]);
            default: elem_ext = signed_q ? OUT_W'($signed(shifted[31:0])) : OUT_W'(shifted[31:0]);
        endcase
    end

    assign run          = (state_q == RUN);
    assign last_in_word = (idx_q == epw_m1) | (remaining_q == LEN_W'(1));
    assign out_valid    = reg_valid_q & enable_i & run;
    assign out_hs       = out_valid & norm_o.ready;
    assign in_ready     = run & enable_i & (~reg_valid_q | (last_in_word & norm_o.ready));
    assign in_hs        = in_ready & norm_i.valid;

    assign norm_i.ready = in_ready;
    assign norm_o.valid = out_valid;
    assign norm_o.data  = reg_valid_q ? elem_ext : '0;
    assign norm_o.strb  = '1;

    assign busy_o  = run;
    assign done_o  = (state_q == DONE);
    assign count_o = count_q;

    // Clear outranks everything; with enable low the whole block holds still.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        signed_d    = signed_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        idx_d       = idx_q;
        word_d      = word_q;
        reg_valid_d = reg_valid_q;

        if (clear_i) begin
            state_d     = IDLE;
            remaining_d = '0;
            count_d     = '0;
            idx_d       = '0;
            reg_valid_d = 1'b0;
        end else if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_d      = mode_i;
                        signed_d    = signed_i;
                        remaining_d = len_i;
                        count_d     = '0;
                        idx_d       = '0;
                        reg_valid_d = 1'b0;
                        state_d     = (len_i != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (out_hs) begin
                        idx_d       = idx_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        count_d     = count_q + 1'b1;
                        if (last_in_word) begin
                            reg_valid_d = 1'b0;
                        end
                    end
                    // The final element retires the job; a word accepted alongside it is dropped.
                    if (out_hs && remaining_q == LEN_W'(1)) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else if (in_hs) begin
                        word_d      = norm_i.data;
                        reg_valid_d = 1'b1;
                        idx_d       = '0;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            signed_q    <= 1'b0;
            remaining_q <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            reg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            signed_q    <= signed_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            reg_valid_q <= reg_valid_d;
        end
    end

endmodule

// File: tb/tb_neureka_norm_serializer.sv
// Directed bench for neureka_norm_serializer: streaming, partial words, backpressure,
// zero-length jobs, ignored restarts, and clear/reset in the middle of a job.
module tb_neureka_norm_serializer;

    localparam int unsigned BW    = 256;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned LEN_W = 16;

    logic             clk;
    logic             rst_n;
    logic             clear_i;
    logic             enable_i;
    logic             start_i;
    logic [1:0]       mode_i;
    logic             signed_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic             done_o;
    logic [LEN_W-1:0] count_o;

    hwpe_stream_intf_stream #(.DATA_WIDTH(BW))    norm_in  ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(OUT_W)) norm_out ();

    neureka_norm_serializer #(.BW(BW), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (clear_i),
        .enable_i (enable_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .signed_i (signed_i),
        .len_i    (len_i),
        .norm_i   (norm_in),
        .norm_o   (norm_out),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .count_o  (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0]    words [0:3];
    logic [OUT_W-1:0] outs  [0:127];
    int nout, n_in, n_done, first_cyc, last_cyc, stab_viol, early_viol;

    task automatic do_start(input logic [1:0] m, input logic s, input int len);
        start_i  = 1'b1;
        mode_i   = m;
        signed_i = s;
        len_i    = LEN_W'(len);
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    // Feeds words and collects outputs each cycle; ends after done_o is seen or budget runs out.
    task automatic run_job(input int nwords, input int len, input int epw, input bit rand_ready,
                           input int max_cyc, input int restart_at, output bit timed_out);
        int wptr;
        bit prev_stall;
        logic [OUT_W-1:0] prev_data;
        wptr = 0; nout = 0; n_in = 0; n_done = 0; first_cyc = 0; last_cyc = 0;
        stab_viol = 0; early_viol = 0; prev_stall = 0; prev_data = '0; timed_out = 1;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            norm_in.valid  = (wptr < nwords);
            norm_in.data   = (wptr < nwords) ? words[wptr] : '0;
            norm_out.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i        = (cyc == restart_at);
            if (cyc == restart_at) len_i = LEN_W'(3);
            #1;
            if (prev_stall && (!norm_out.valid || norm_out.data !== prev_data)) stab_viol++;
            if (norm_out.valid && norm_in.ready && (nout % epw) != epw - 1 && nout != len - 1)
                early_viol++;
            if (done_o) begin
                n_done++;
                timed_out = 0;
            end
            if (norm_out.valid && norm_out.ready) begin
                if (nout < 128) outs[nout] = norm_out.data;
                if (nout == 0) first_cyc = cyc;
                last_cyc = cyc;
                nout++;
            end
            if (norm_in.valid && norm_in.ready) begin
                n_in++;
                wptr++;
            end
            prev_stall = norm_out.valid && !norm_out.ready;
            prev_data  = norm_out.data;
            @(negedge clk);
            if (!timed_out) break;
        end
        start_i        = 1'b0;
        norm_in.valid  = 1'b0;
        norm_out.ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || count_o !== '0 || norm_out.valid !== 1'b0 ||
            norm_out.data !== '0 || norm_in.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b done=%b count=%0d oval=%b odata=%h iready=%b, required all zero",
                     busy_o, done_o, count_o, norm_out.valid, norm_out.data, norm_in.ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_8b_back_to_back();
        bit to;
        int bad, extra;
        for (int b = 0; b < 32; b++) begin
            words[0][b*8 +: 8] = 8'(b);
            words[1][b*8 +: 8] = 8'(b + 32);
        end
        do_start(2'b00, 1'b0, 64);
        checks++;
        if (norm_out.strb !== 4'hF) begin
            errors++;
            $display("[TB] FAIL t1_strb: got %h, required f", norm_out.strb);
        end
        run_job(2, 64, 32, 1'b0, 200, -1, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL t1_timeout: done_o never seen, required within 200 cycles"); end
        checks++;
        if (nout != 64) begin errors++; $display("[TB] FAIL t1_nout: got %0d, required 64", nout); end
        bad = 0;
        for (int k = 0; k < 64 && k < nout; k++) if (outs[k] !== 32'(k)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL t1_data: %0d wrong elements, required 0", bad); end
        checks++;
        if (last_cyc - first_cyc != 63) begin
            errors++;
            $display("[TB] FAIL t1_no_bubble: span %0d cycles, required 63", last_cyc - first_cyc);
        end
        checks++;
        if (n_in != 2) begin errors++; $display("[TB] FAIL t1_in_hs: got %0d, required 2", n_in); end
        checks++;
        if (n_done != 1 || count_o !== 16'd64) begin
            errors++;
            $display("[TB] FAIL t1_done_count: done=%0d count=%0d, required 1 and 64", n_done, count_o);
        end
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (done_o) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0) begin errors++; $display("[TB] FAIL t1_single_done: extra pulses %0d, required 0", extra); end
    endtask

    task automatic test_16b_signed_partial();
        bit to;
        int bad, rdy;
        logic [31:0] exp [0:4];
        words[0] = {16{16'h1234}};
        words[0][15:0]  = 16'hFFFF;
        words[0][31:16] = 16'h8000;
        words[0][47:32] = 16'h7FFF;
        words[0][63:48] = 16'h0001;
        words[0][79:64] = 16'h0000;
        exp[0] = 32'hFFFFFFFF; exp[1] = 32'hFFFF8000; exp[2] = 32'h00007FFF;
        exp[3] = 32'h00000001; exp[4] = 32'h00000000;
        do_start(2'b01, 1'b1, 5);
        run_job(1, 5, 16, 1'b0, 100, -1, to);
        checks++;
        if (to || nout != 5 || n_in != 1) begin
            errors++;
            $display("[TB] FAIL t2_shape: timeout=%0d nout=%0d in_hs=%0d, required 0 5 1", to, nout, n_in);
        end
        bad = 0;
        for (int k = 0; k < 5; k++) if (outs[k] !== exp[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL t2_data: %0d wrong, got %h %h %h %h %h, required ffffffff ffff8000 00007fff 00000001 00000000",
                     bad, outs[0], outs[1], outs[2], outs[3], outs[4]);
        end
        checks++;
        if (count_o !== 16'd5) begin errors++; $display("[TB] FAIL t2_count: got %0d, required 5", count_o); end
        norm_in.valid = 1'b1;
        norm_in.data  = words[0];
        rdy = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (norm_in.ready) rdy++;
            @(negedge clk);
        end
        norm_in.valid = 1'b0;
        checks++;
        if (rdy != 0) begin errors++; $display("[TB] FAIL t2_ready_after: ready high %0d cycles, required 0", rdy); end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad;
        for (int k = 0; k < 8; k++) begin
            words[0][k*32 +: 32] = 32'hC0DE0000 | 32'(k);
            words[1][k*32 +: 32] = 32'hC0DE0000 | 32'(k + 8);
        end
        do_start(2'b10, 1'b0, 16);
        run_job(2, 16, 8, 1'b1, 400, -1, to);
        checks++;
        if (to || nout != 16 || n_in != 2) begin
            errors++;
            $display("[TB] FAIL t3_shape: timeout=%0d nout=%0d in_hs=%0d, required 0 16 2", to, nout, n_in);
        end
        bad = 0;
        for (int k = 0; k < 16 && k < nout; k++) if (outs[k] !== (32'hC0DE0000 | 32'(k))) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL t3_data: %0d wrong elements, required 0", bad); end
        checks++;
        if (stab_viol != 0) begin errors++; $display("[TB] FAIL t3_stable: %0d violations, required 0", stab_viol); end
        checks++;
        if (early_viol != 0) begin errors++; $display("[TB] FAIL t3_one_word: %0d early ready, required 0", early_viol); end
        checks++;
        if (count_o !== 16'd16) begin errors++; $display("[TB] FAIL t3_count: got %0d, required 16", count_o); end
    endtask

    task automatic test_len0_and_restart();
        bit to;
        int bad;
        norm_in.valid = 1'b1;
        norm_in.data  = '1;
        do_start(2'b00, 1'b0, 0);
        #1;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || norm_in.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t4_len0: done=%b busy=%b iready=%b, required 1 0 0", done_o, busy_o, norm_in.ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0 || norm_in.ready !== 1'b0 || count_o !== '0) begin
            errors++;
            $display("[TB] FAIL t4_len0_after: done=%b iready=%b count=%0d, required 0 0 0", done_o, norm_in.ready, count_o);
        end
        norm_in.valid = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 32; b++) words[0][b*8 +: 8] = 8'(b + 16);
        do_start(2'b00, 1'b0, 8);
        run_job(1, 8, 32, 1'b0, 100, 3, to);
        bad = 0;
        for (int k = 0; k < 8 && k < nout; k++) if (outs[k] !== 32'(k + 16)) bad++;
        checks++;
        if (to || nout != 8 || count_o !== 16'd8 || n_done != 1 || bad != 0) begin
            errors++;
            $display("[TB] FAIL t4_restart_ignored: timeout=%0d nout=%0d count=%0d done=%0d bad=%0d, required 0 8 8 1 0",
                     to, nout, count_o, n_done, bad);
        end
    endtask

    // Brings a len-32 8b job to its fourth element, then a fresh len-4 job after the abort.
    task automatic partial_job(input int base);
        bit to;
        for (int b = 0; b < 32; b++) words[0][b*8 +: 8] = 8'(b + base);
        do_start(2'b00, 1'b0, 32);
        run_job(1, 32, 32, 1'b0, 4, -1, to);
    endtask

    task automatic fresh_job(input string tag);
        bit to;
        int bad;
        for (int b = 0; b < 32; b++) words[0][b*8 +: 8] = 8'(b + 8'h50);
        do_start(2'b00, 1'b0, 4);
        run_job(1, 4, 32, 1'b0, 50, -1, to);
        bad = 0;
        for (int k = 0; k < 4 && k < nout; k++) if (outs[k] !== 32'(k + 8'h50)) bad++;
        checks++;
        if (to || nout != 4 || bad != 0 || count_o !== 16'd4 || n_done != 1) begin
            errors++;
            $display("[TB] FAIL %s_fresh: timeout=%0d nout=%0d bad=%0d count=%0d done=%0d, required 0 4 0 4 1",
                     tag, to, nout, bad, count_o, n_done);
        end
    endtask

    task automatic test_clear_mid_job();
        int dn;
        partial_job(8'hA0);
        checks++;
        if (nout != 3 || outs[2] !== 32'hA2) begin
            errors++;
            $display("[TB] FAIL t5_pre_clear: nout=%0d last=%h, required 3 and a2", nout, outs[2]);
        end
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || norm_out.valid !== 1'b0 || count_o !== '0 || done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t5_clear: busy=%b oval=%b count=%0d done=%b, required 0 0 0 0",
                     busy_o, norm_out.valid, count_o, done_o);
        end
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (done_o) dn++;
        end
        checks++;
        if (dn != 0) begin errors++; $display("[TB] FAIL t5_no_done: %0d pulses, required 0", dn); end
        @(negedge clk);
        fresh_job("t5_clear");
    endtask

    task automatic test_reset_mid_job();
        partial_job(8'hB0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || norm_out.valid !== 1'b0 || norm_out.data !== '0 || count_o !== '0 ||
            done_o !== 1'b0 || norm_in.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t5_async_reset: busy=%b oval=%b odata=%h count=%0d done=%b iready=%b, required all zero",
                     busy_o, norm_out.valid, norm_out.data, count_o, done_o, norm_in.ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fresh_job("t5_reset");
    endtask

    initial begin
        clear_i        = 1'b0;
        enable_i       = 1'b1;
        start_i        = 1'b0;
        mode_i         = 2'b00;
        signed_i       = 1'b0;
        len_i          = '0;
        norm_in.valid  = 1'b0;
        norm_in.data   = '0;
        norm_in.strb   = '1;
        norm_out.ready = 1'b1;
        for (int i = 0; i < 4; i++) words[i] = '0;

        test_reset();
        test_8b_back_to_back();
        test_16b_signed_partial();
        test_backpressure();
        test_len0_and_restart();
        test_clear_mid_job();
        test_reset_mid_job();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neureka_norm_serializer.md
Name: neureka_norm_serializer

Overview:
- Sits directly downstream of the streamer's norm_o output.
- Accepts BW-wide normalization/scale words and emits one element per handshake as an OUT_W-wide stream, for the per-column normalization/quantization stage.
- Elements in each word are 8, 16 or 32 bits, selected by mode; the element count per job is programmable.
- A one-word holding register with same-cycle refill allows one element per cycle when there is no backpressure.

Parameters:
- BW, NEUREKA_MEM_BANDWIDTH_EXT (256): input stream data width; must be a multiple of 32.
- OUT_W, 32: output element width; must be ≥32.
- LEN_W, 16: width of the element-count register.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous soft clear.
- enable_i  in  1  gates all handshakes; when 0, valid and ready are held low and state is frozen.
- start_i  in  1  one-cycle pulse; latches mode_i, signed_i and len_i.
- mode_i  in  2  element width: 00 = 8b, 01 = 16b, 10 = 32b, 11 = reserved, treated as 32b.
- signed_i  in  1  1 = sign-extend to OUT_W, 0 = zero-extend.
- len_i  in  LEN_W  total number of elements in the job.
- norm_i  sink  hwpe_stream_intf_stream (DATA_WIDTH=BW)  packed input words.
- norm_o  source  hwpe_stream_intf_stream (DATA_WIDTH=OUT_W)  serialized elements.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse at job end.
- count_o  out  LEN_W  elements emitted in the current job.

Behaviour:
- Reset: async on rst_ni low. State = IDLE; holding register, reg_valid, element index, remaining and count_o = 0; busy_o = 0, done_o = 0; norm_i.ready = 0; norm_o.valid = 0; norm_o.data = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i with len_i ≠ 0.
  - IDLE -> DONE on start_i with len_i = 0. No input word is consumed.
  - RUN -> DONE on the output handshake that brings remaining to 0.
  - DONE -> IDLE unconditionally after 1 cycle; done_o = 1 only in DONE.
  - start_i outside IDLE is ignored.
- Elements per word: EPW = BW/8, BW/16 or BW/32 by the latched mode.
- Element k of a word occupies bits [k·EW +: EW], so element 0 is in the LSBs.
- Input side:
  - norm_i.ready = (state == RUN) & enable_i & (~reg_valid | (last_in_word & norm_o.ready)).
  - last_in_word = (idx == EPW−1) | (remaining == 1).
  - A handshake loads the holding register, sets reg_valid = 1 and sets idx = 0.
  - Same-cycle refill: when the final element of a word handshakes and a new word handshakes together, the new word is loaded with no bubble.
- Output side:
  - norm_o.valid = reg_valid & enable_i & (state == RUN).
  - norm_o.data = element[idx], extended to OUT_W per the latched signed flag; norm_o.strb is all ones.
  - Data is combinational from the register: 0-cycle latency from register to output, 1 cycle from input handshake to first output valid.
  - Valid, once asserted, stays asserted with stable data until ready (no retraction).
- On each output handshake: idx++, remaining--, count_o++.
  - If last_in_word and there is no simultaneous refill: reg_valid = 0.
  - When remaining reaches 0, any unconsumed elements left in the word are discarded, reg_valid = 0, and the word counts as consumed.
- Partial last word: the upstream word is still fully accepted; only remaining elements are emitted.
- count_o resets to 0 on start_i and holds its final value through DONE and IDLE until the next start.
- clear_i (synchronous, has priority over start_i and handshakes):
  - state = IDLE; reg_valid, idx, remaining and count_o = 0; no done pulse.
  - Mid-job clear drops the buffered word.
- Reset mid-operation behaves as clear, but asynchronously.

Test Plan:
- **T1, 8b unsigned, back-to-back:** mode 00, len 64, 2 words with bytes = index, ready always 1. Expected:
  - 64 outputs 0..63 on consecutive cycles, no bubble at the word boundary;
  - exactly 2 input handshakes;
  - done_o pulses once; count_o = 64.
- **T2, 16b signed partial word:** mode 01, signed, len 5, word halfwords = 0xFFFF, 0x8000, 0x7FFF, 0x0001, 0x0000, … Expected:
  - outputs 0xFFFFFFFF, 0xFFFF8000, 0x00007FFF, 0x00000001, 0x00000000;
  - the rest of the word is discarded and norm_i.ready stays 0 after the job.
- **T3, backpressure:** mode 10, len 16, norm_o.ready random 50%. Expected:
  - 16 elements in order; data stable while valid & ~ready;
  - at most 1 word held, so norm_i.ready is never high while a non-final element is pending.
- **T4, len 0 and ignored start:** start with len 0. Expected:
  - done_o one cycle later, no input handshake;
  - a start_i during RUN of a len-8 job does not restart it (count_o reaches 8).
- **T5, clear/reset mid-job:** clear_i at element 3 of a len-32 8b job. Expected:
  - next cycle: busy_o 0, norm_o.valid 0, count_o 0, no done pulse;
  - a fresh start runs cleanly;
  - the same test repeated with rst_ni low asynchronously mid-cycle gives all outputs at reset values immediately.
